// File: rtl/vwb_pkg.sv
// Shared definitions for the victim write buffer: FSM state encoding,
// default geometry and the small sizing helpers used by the top and the entry array.
package vwb_pkg;

    localparam int DEF_WIDTH      = 256;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        DRAIN = 2'd2,
        FETCH = 2'd3
    } vwb_state_e;

    // Number of byte-offset bits below the line address.
    function automatic int line_offset(input int width);
        return (width > 8) ? $clog2(width / 8) : 0;
    endfunction

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vwb_entry_array.sv
// Line storage for the victim write buffer: DEPTH entries of {valid, line tag, data}
// with one write port, one invalidate port, a head read port and a one-hot tag lookup.
module vwb_entry_array
    import vwb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_ADDR_WIDTH - line_offset(DEF_WIDTH),
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = ptr_bits(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inv_en,
    input  logic [PTR_W-1:0] inv_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic [DEPTH-1:0] match,
    output logic             hit,
    output logic [PTR_W-1:0] hit_idx,
    output logic [WIDTH-1:0] hit_data,
    input  logic [PTR_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic [WIDTH-1:0] rd_data
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t entries_r [DEPTH];

    // Entry storage: write-at-index sets valid, invalidate-at-index clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                entries_r[wr_idx].valid <= 1'b1;
                entries_r[wr_idx].tag   <= wr_tag;
                entries_r[wr_idx].data  <= wr_data;
            end
            if (inv_en) begin
                entries_r[inv_idx].valid <= 1'b0;
            end
        end
    end

    // One-hot tag match across all valid entries.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entries_r[i].valid && (entries_r[i].tag == lookup_tag);
        end
    end

    // At most one entry matches, so OR-reduction doubles as the encoder and data mux.
    always_comb begin
        hit_idx  = '0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_idx  = hit_idx | (match[i] ? PTR_W'(i) : '0);
            hit_data = hit_data | ({WIDTH{match[i]}} & entries_r[i].data);
        end
        hit = |match;
    end

    assign rd_tag  = entries_r[rd_idx].tag;
    assign rd_data = entries_r[rd_idx].data;

endmodule

// File: rtl/victim_write_buffer.sv
// Multi-entry victim write buffer: coalesces evictions, serves read hits from buffered
// lines and drains oldest-first to the downstream port whenever it is otherwise idle.
module victim_write_buffer
    import vwb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [WIDTH-1:0]      pmem_wdata,
    input  logic [WIDTH-1:0]      pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  empty,
    output logic                  full
);

    localparam int OFF   = line_offset(WIDTH);
    localparam int TAG_W = ADDR_WIDTH - OFF;
    localparam int PTR_W = ptr_bits(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    vwb_state_e              state_r, state_next_s;
    logic [PTR_W-1:0]        head_r, head_next_s;
    logic [PTR_W-1:0]        tail_r, tail_next_s;
    logic [CNT_W-1:0]        count_r, count_next_s;
    logic                    resp_r, pmem_read_r, pmem_write_r;
    logic                    full_r, empty_r;
    logic [WIDTH-1:0]        rdata_r, rdata_next_s;
    logic [ADDR_WIDTH-1:0]   pmem_address_r, pmem_address_next_s;
    logic [WIDTH-1:0]        pmem_wdata_r, pmem_wdata_next_s;

    logic [TAG_W-1:0]        tag_s;
    logic                    wr_en_s, inv_en_s;
    logic [PTR_W-1:0]        wr_idx_s;
    logic [DEPTH-1:0]        match_s;
    logic                    hit_s;
    logic [PTR_W-1:0]        hit_idx_s;
    logic [WIDTH-1:0]        hit_data_s;
    logic [TAG_W-1:0]        head_tag_s;
    logic [WIDTH-1:0]        head_data_s;

    assign tag_s = address[ADDR_WIDTH-1:OFF];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    vwb_entry_array #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_entries (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en_s),
        .wr_idx     (wr_idx_s),
        .wr_tag     (tag_s),
        .wr_data    (wdata),
        .inv_en     (inv_en_s),
        .inv_idx    (head_r),
        .lookup_tag (tag_s),
        .match      (match_s),
        .hit        (hit_s),
        .hit_idx    (hit_idx_s),
        .hit_data   (hit_data_s),
        .rd_idx     (head_r),
        .rd_tag     (head_tag_s),
        .rd_data    (head_data_s)
    );

    // Next-state, pointer/count updates and the values to register on the outputs.
    always_comb begin
        state_next_s        = state_r;
        head_next_s         = head_r;
        tail_next_s         = tail_r;
        count_next_s        = count_r;
        wr_en_s             = 1'b0;
        wr_idx_s            = tail_r;
        inv_en_s            = 1'b0;
        rdata_next_s        = rdata_r;
        pmem_address_next_s = pmem_address_r;
        pmem_wdata_next_s   = pmem_wdata_r;
        case (state_r)
            IDLE: begin
                if (write) begin
                    if (hit_s) begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = hit_idx_s;
                        state_next_s = RESP;
                    end else if (!full_r) begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = tail_r;
                        tail_next_s  = ptr_inc(tail_r);
                        count_next_s = count_r + CNT_W'(1);
                        state_next_s = RESP;
                    end else begin
                        // Make room; the write is seen again once the drain completes.
                        pmem_address_next_s = ADDR_WIDTH'(head_tag_s) << OFF;
                        pmem_wdata_next_s   = head_data_s;
                        state_next_s        = DRAIN;
                    end
                end else if (read) begin
                    if (hit_s) begin
                        rdata_next_s = hit_data_s;
                        state_next_s = RESP;
                    end else begin
                        pmem_address_next_s = address;
                        state_next_s        = FETCH;
                    end
                end else if (!empty_r) begin
                    pmem_address_next_s = ADDR_WIDTH'(head_tag_s) << OFF;
                    pmem_wdata_next_s   = head_data_s;
                    state_next_s        = DRAIN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            DRAIN: begin
                if (pmem_resp) begin
                    inv_en_s     = 1'b1;
                    head_next_s  = ptr_inc(head_r);
                    count_next_s = count_r - CNT_W'(1);
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    rdata_next_s = pmem_rdata;
                    state_next_s = RESP;
                end else begin
                    state_next_s = FETCH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, pointers and registered outputs; handshake strobes decode the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            head_r         <= '0;
            tail_r         <= '0;
            count_r        <= '0;
            resp_r         <= 1'b0;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            rdata_r        <= '0;
            pmem_address_r <= '0;
            pmem_wdata_r   <= '0;
        end else begin
            state_r        <= state_next_s;
            head_r         <= head_next_s;
            tail_r         <= tail_next_s;
            count_r        <= count_next_s;
            resp_r         <= (state_next_s == RESP);
            pmem_read_r    <= (state_next_s == FETCH);
            pmem_write_r   <= (state_next_s == DRAIN);
            full_r         <= (count_next_s == CNT_W'(DEPTH));
            empty_r        <= (count_next_s == CNT_W'(0));
            rdata_r        <= rdata_next_s;
            pmem_address_r <= pmem_address_next_s;
            pmem_wdata_r   <= pmem_wdata_next_s;
        end
    end

    assign rdata        = rdata_r;
    assign resp         = resp_r;
    assign pmem_address = pmem_address_r;
    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_wdata   = pmem_wdata_r;
    assign full         = full_r;
    assign empty        = empty_r;

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed bench for victim_write_buffer (DEPTH=4, 256-bit lines): write/coalesce/fill,
// read hit and miss ordering, and reset during an in-flight drain.
module tb_victim_write_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  address;
    logic         read, write;
    logic [255:0] wdata, rdata;
    logic         resp;
    logic [31:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         empty, full;

    int total = 0;
    int bad   = 0;

    logic [255:0] d1, d2, d3, d4, d5, d6;

    victim_write_buffer #(.WIDTH(256), .ADDR_WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .wdata        (wdata),
        .rdata        (rdata),
        .resp         (resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .empty        (empty),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a drain, checks its address/data, then completes it.
    task automatic drain_expect(input string tag, input logic [31:0] a, input logic [255:0] d);
        int n;
        n = 0;
        while (!pmem_write && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, pmem_write, 1'b1);
        chk({tag, "_addr"}, pmem_address, a);
        chk({tag, "_data"}, pmem_wdata, d);
        chk({tag, "_no_rd"}, pmem_read, 1'b0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk({tag, "_done"}, pmem_write, 1'b0);
    endtask

    // Simultaneous read and write is an upstream protocol violation.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(read && write)) else begin
                bad++;
                $error("FAIL illegal_rw observed=1 expected=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d1 = {8{32'h1111_0001}};
        d2 = {8{32'h2222_0002}};
        d3 = {8{32'h3333_0003}};
        d4 = {8{32'h4444_0004}};
        d5 = {8{32'h5555_0005}};
        d6 = {8{32'h6666_0006}};
        reset = 1'b1; address = 32'h0; read = 1'b0; write = 1'b0;
        wdata = 256'h0; pmem_rdata = 256'h0; pmem_resp = 1'b0;
        tick(); tick();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_resp", resp, 1'b0);
        chk("rst_pwrite", pmem_write, 1'b0);
        chk("rst_pread", pmem_read, 1'b0);
        chk("rst_rdata", rdata, 256'h0);
        chk("rst_paddr", pmem_address, 32'h0);
        reset = 1'b0;
        tick();

        // 1: single write, resp on 2nd cycle, then idle drain
        write = 1'b1; address = 32'h100; wdata = d1;
        tick();
        chk("t1_resp", resp, 1'b1);
        chk("t1_no_pw", pmem_write, 1'b0);
        chk("t1_not_empty", empty, 1'b0);
        chk("t1_not_full", full, 1'b0);
        write = 1'b0;
        tick();
        chk("t1_resp_pulse", resp, 1'b0);
        chk("t1_no_pw2", pmem_write, 1'b0);
        tick();
        drain_expect("t1_drain", 32'h100, d1);
        chk("t1_empty", empty, 1'b1);

        // 2: coalescing write to the same line before any drain
        write = 1'b1; address = 32'h100; wdata = d1;
        tick();
        chk("t2_resp1", resp, 1'b1);
        wdata = d2;
        tick();
        chk("t2_resp_gap", resp, 1'b0);
        tick();
        chk("t2_resp2", resp, 1'b1);
        chk("t2_count1_empty", empty, 1'b0);
        chk("t2_count1_full", full, 1'b0);
        write = 1'b0;
        drain_expect("t2_drain", 32'h100, d2);
        chk("t2_empty", empty, 1'b1);

        // 3: fill back-to-back, fifth write stalls behind the head drain
        write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            address = 32'h20 * k;
            wdata = {8{32'hA000_0000 + k}};
            tick();
            chk("t3_fill_resp", resp, 1'b1);
            if (k < 3) begin
                tick();
            end
        end
        chk("t3_full", full, 1'b1);
        address = 32'h080; wdata = {8{32'hA000_0004}};
        tick();
        chk("t3_idle_resp", resp, 1'b0);
        tick();
        chk("t3_stall_pw", pmem_write, 1'b1);
        chk("t3_stall_addr", pmem_address, 32'h000);
        chk("t3_stall_data", pmem_wdata, {8{32'hA000_0000}});
        tick(); tick();
        chk("t3_stall_resp", resp, 1'b0);
        chk("t3_stall_hold", pmem_write, 1'b1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t3_room_full", full, 1'b0);
        chk("t3_room_resp", resp, 1'b0);
        tick();
        chk("t3_accept_resp", resp, 1'b1);
        chk("t3_accept_full", full, 1'b1);
        write = 1'b0;
        drain_expect("t3_d1", 32'h020, {8{32'hA000_0001}});
        drain_expect("t3_d2", 32'h040, {8{32'hA000_0002}});
        drain_expect("t3_d3", 32'h060, {8{32'hA000_0003}});
        drain_expect("t3_d4", 32'h080, {8{32'hA000_0004}});
        chk("t3_empty", empty, 1'b1);

        // 4: read hit served from the buffer
        write = 1'b1; address = 32'h200; wdata = d3;
        tick();
        chk("t4_wresp", resp, 1'b1);
        write = 1'b0; read = 1'b1;
        tick();
        chk("t4_gap", resp, 1'b0);
        tick();
        chk("t4_rresp", resp, 1'b1);
        chk("t4_rdata", rdata, d3);
        chk("t4_no_pr", pmem_read, 1'b0);
        chk("t4_no_pw", pmem_write, 1'b0);
        read = 1'b0;

        // 5: read miss waits for the in-flight drain, then fetches
        tick(); tick();
        chk("t5_drain_pw", pmem_write, 1'b1);
        chk("t5_drain_addr", pmem_address, 32'h200);
        chk("t5_drain_data", pmem_wdata, d3);
        read = 1'b1; address = 32'h300;
        tick();
        chk("t5_wait_pr", pmem_read, 1'b0);
        chk("t5_wait_resp", resp, 1'b0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t5_drain_done", pmem_write, 1'b0);
        chk("t5_not_yet_pr", pmem_read, 1'b0);
        tick();
        chk("t5_fetch_pr", pmem_read, 1'b1);
        chk("t5_fetch_addr", pmem_address, 32'h300);
        chk("t5_fetch_no_pw", pmem_write, 1'b0);
        tick();
        chk("t5_fetch_hold", pmem_read, 1'b1);
        pmem_rdata = d4; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t5_resp", resp, 1'b1);
        chk("t5_rdata", rdata, d4);
        chk("t5_pr_drop", pmem_read, 1'b0);
        chk("t5_empty", empty, 1'b1);
        read = 1'b0;
        tick();

        // 6: asynchronous reset during a drain
        write = 1'b1; address = 32'h400; wdata = d5;
        tick();
        chk("t6_wresp", resp, 1'b1);
        write = 1'b0;
        tick(); tick();
        chk("t6_drain_pw", pmem_write, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_rst_pw", pmem_write, 1'b0);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_resp", resp, 1'b0);
        chk("t6_rst_paddr", pmem_address, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_idle_pw", pmem_write, 1'b0);
        write = 1'b1; address = 32'h500; wdata = d6;
        tick();
        chk("t6_new_resp", resp, 1'b1);
        write = 1'b0;
        drain_expect("t6_drain", 32'h500, d6);
        chk("t6_empty", empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/victim_write_buffer.md
Name: victim_write_buffer

Overview:
- Parametrised successor to the single-entry eviction write buffer.
- Holds up to DEPTH evicted dirty lines between a cache (L1D or L2) and the next level down.
- Coalesces repeat writes to the same line, serves read hits from buffered lines, and drains oldest-first to the downstream port whenever that port is otherwise idle.
- Sits between the cache's memory-side port and the arbiter or physical memory.

Parameters:
- WIDTH, 256, line width in bits for wdata/rdata on both sides.
- ADDR_WIDTH, 32, address width. Addresses are line-aligned; the low log2(WIDTH/8) bits are ignored in matching.
- DEPTH, 4, number of line entries. Power of two, at least 1.

Ports:
- clk  in  1  clock, all state rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  upstream request line address.
- read  in  1  upstream line read request, held until resp.
- write  in  1  upstream line write (eviction), held until resp.
- wdata  in  WIDTH  upstream write line.
- rdata  out  WIDTH  upstream read line, valid while resp=1.
- resp  out  1  one-cycle upstream completion pulse.
- pmem_address  out  ADDR_WIDTH  downstream address.
- pmem_read  out  1  downstream read, held until pmem_resp.
- pmem_write  out  1  downstream write, held until pmem_resp.
- pmem_wdata  out  WIDTH  downstream write line.
- pmem_rdata  in  WIDTH  downstream read line, valid with pmem_resp.
- pmem_resp  in  1  one-cycle downstream completion.
- empty  out  1  no valid entries.
- full  out  1  all DEPTH entries valid.

Behaviour:
- Reset (asynchronous): all entries invalid, head/tail/count = 0, FSM = IDLE. resp, pmem_read and pmem_write go to 0 immediately; rdata and pmem_address go to 0. empty=1, full=0.
- Reset mid-transfer abandons the downstream transaction; buffered dirty lines are discarded. This is accepted behaviour.
- Entries: circular FIFO (head = oldest). Each entry holds valid, line address and data. Match = valid and line address equal; at most one entry ever matches.
- FSM states: IDLE, RESP, DRAIN, FETCH.
- IDLE priority, evaluated each cycle:
  1. write, match: overwrite that entry's data in place (FIFO position unchanged) -> RESP.
  2. write, no match, not full: store at tail, tail++, count++ -> RESP.
  3. write, no match, full: -> DRAIN on head; the write is re-evaluated on return to IDLE.
  4. read, match: latch entry data into rdata -> RESP, with no pmem access.
  5. read, no match: -> FETCH.
  6. no request and not empty: -> DRAIN on head.
  7. otherwise stay in IDLE.
- read and write both high is illegal. The block treats it as a write, and the bench flags it.
- RESP: resp=1 for exactly one cycle. Upstream request inputs are ignored in this cycle. -> IDLE.
  - Write latency: resp on cycle 2 after the request is first sampled.
  - Read-hit latency: the same, 2 cycles.
- DRAIN:
  - pmem_write=1 with pmem_address/pmem_wdata from head, held stable until pmem_resp.
  - On pmem_resp: head entry invalidated, head++, count--, -> IDLE.
  - Not abortable. Requests arriving meanwhile wait.
- FETCH:
  - pmem_read=1 with pmem_address = upstream address, held until pmem_resp.
  - On pmem_resp: rdata <= pmem_rdata -> RESP.
  - Ordering is safe because a missing address has no buffered copy.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- full = (count==DEPTH); empty = (count==0); both registered from count.
- Write coalescing when full: a matching write to a full buffer is accepted immediately, with no drain.
- pmem_read and pmem_write are never both 1.
- resp never asserts without a sampled request.

Decomposition:
- Package vwb_pkg:
  - state enum (IDLE, RESP, DRAIN, FETCH);
  - entry struct parametrised by WIDTH/ADDR_WIDTH;
  - line-offset constant function.
- Sub-module vwb_entry_array:
  - registered storage for DEPTH entries with write-at-index and invalidate-at-index;
  - combinational one-hot match vector plus encoded hit index.
- Top-level vwb FSM: pointers, count and both handshakes.

Test Plan:
1. DEPTH=4. Write line A=0x100, data D1 -> resp on 2nd cycle, no pmem activity, count=1. Then idle -> pmem_write for 0x100/D1; after pmem_resp, empty=1.
2. Write 0x100/D1, then 0x100/D2 before drain (pmem_resp withheld) -> count stays 1. The drained data is D2.
3. Fill four lines 0x000,0x020,0x040,0x060 with pmem_resp withheld -> full=1. A fifth write 0x080 stalls until the 0x000 drain pmem_resp, then is accepted and count=4.
4. Buffer 0x200/D3, then read 0x200 -> rdata=D3 with resp, and no pmem_read asserted.
5. Read miss 0x300 while a drain of 0x200 is in flight -> pmem_write completes first, then pmem_read 0x300. pmem_rdata is returned on upstream rdata with resp one cycle after pmem_resp.
6. Assert reset during DRAIN -> pmem_write drops in the same cycle, empty=1, resp=0. After release, a new write is accepted normally.
